// File: rtl/ftl_op_arb_if.sv
// Client-channel and op_page signal bundle around ftl_op_arb.
// The arbiter takes the slave view; the clients plus ftl_physical take the master view.
interface ftl_op_arb_if #(
  parameter int NCH = 4,
  parameter int PW  = 16,
  parameter int BW  = 16,
  parameter int SW  = 42
);
  logic [NCH-1:0]    ch_do;
  logic [NCH*3-1:0]  ch_cmd;
  logic [NCH*PW-1:0] ch_num;
  logic [NCH*BW-1:0] ch_bram;
  logic [NCH*SW-1:0] ch_spare_wr;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_done;
  logic              ch_status;
  logic [SW-1:0]     ch_spare_rd;

  logic              op_page_do;
  logic [2:0]        op_page_cmd;
  logic [PW-1:0]     op_page_num;
  logic [BW-1:0]     op_page_bram;
  logic [SW-1:0]     op_page_spare_wr;
  logic              op_page_status;
  logic [SW-1:0]     op_page_spare_rd;
  logic              op_page_ack;
  logic              op_page_done;

  modport slave (
    input  ch_do, ch_cmd, ch_num, ch_bram, ch_spare_wr,
    input  op_page_status, op_page_spare_rd, op_page_ack, op_page_done,
    output ch_ack, ch_done, ch_status, ch_spare_rd,
    output op_page_do, op_page_cmd, op_page_num, op_page_bram, op_page_spare_wr
  );

  modport master (
    output ch_do, ch_cmd, ch_num, ch_bram, ch_spare_wr,
    output op_page_status, op_page_spare_rd, op_page_ack, op_page_done,
    input  ch_ack, ch_done, ch_status, ch_spare_rd,
    input  op_page_do, op_page_cmd, op_page_num, op_page_bram, op_page_spare_wr
  );
endinterface

// File: rtl/ftl_op_arb.sv
// Round-robin arbiter funnelling NCH client page operations onto the single ftl_physical op_page port.
// Define FTL_OP_TIMEOUT_EN to add the op watchdog (err_timeout); without it err_timeout is tied 0.
//   state     | meaning
//   IDLE      | no op outstanding, arbitrating ch_do
//   ISSUE     | op_page_do held, waiting for op_page_ack
//   WAIT_DONE | accepted by physical, waiting for op_page_done
module ftl_op_arb #(
  parameter int  NCH         = 4,
  parameter int  PW          = 16,
  parameter int  BW          = 16,
  parameter int  SW          = 42,
  parameter int  TIMEOUT_CYC = 1000000,
  localparam int IW          = $clog2(NCH)
) (
  input  logic          clk_50,
  input  logic          reset_n,
  ftl_op_arb_if.slave   bus,
  output logic [IW-1:0] grant_idx,
  output logic          busy,
  output logic          err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_q, last_nx;
  logic [IW-1:0]   grant_q, grant_nx;
  logic [IW-1:0]   pick;
  logic            found;
  logic            load;
  logic            do_q, do_nx;
  logic [NCH-1:0]  ack_q, ack_nx;
  logic [NCH-1:0]  done_q, done_nx;
  logic            status_q, status_nx;
  logic [SW-1:0]   srd_q, srd_nx;
  logic [2:0]      cmd_q;
  logic [PW-1:0]   num_q;
  logic [BW-1:0]   bram_q;
  logic [SW-1:0]   swr_q;
  logic            timeout_hit;

  // Search starts just past the last completed channel so it loses ties.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!found && bus.ch_do[(int'(last_q) + k) % NCH]) begin
        found = 1'b1;
        pick  = IW'((int'(last_q) + k) % NCH);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    last_nx   = last_q;
    grant_nx  = grant_q;
    do_nx     = do_q;
    ack_nx    = '0;
    done_nx   = '0;
    status_nx = status_q;
    srd_nx    = srd_q;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          load     = 1'b1;
          do_nx    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.op_page_ack && bus.op_page_done) begin
          ack_nx[grant_q]  = 1'b1;
          done_nx[grant_q] = 1'b1;
          do_nx            = 1'b0;
          status_nx        = bus.op_page_status;
          srd_nx           = bus.op_page_spare_rd;
          last_nx          = grant_q;
          state_nx         = IDLE;
        end else if (timeout_hit) begin
          // The client never saw its ack, so it gets one alongside the failed done.
          ack_nx[grant_q]  = 1'b1;
          done_nx[grant_q] = 1'b1;
          do_nx            = 1'b0;
          status_nx        = 1'b1;
          srd_nx           = '0;
          last_nx          = grant_q;
          state_nx         = IDLE;
        end else if (bus.op_page_ack) begin
          ack_nx[grant_q] = 1'b1;
          do_nx           = 1'b0;
          state_nx        = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.op_page_done) begin
          done_nx[grant_q] = 1'b1;
          status_nx        = bus.op_page_status;
          srd_nx           = bus.op_page_spare_rd;
          last_nx          = grant_q;
          state_nx         = IDLE;
        end else if (timeout_hit) begin
          done_nx[grant_q] = 1'b1;
          status_nx        = 1'b1;
          srd_nx           = '0;
          last_nx          = grant_q;
          state_nx         = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_q   <= IW'(NCH - 1);
      grant_q  <= '0;
      do_q     <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      status_q <= 1'b0;
      srd_q    <= '0;
      cmd_q    <= '0;
      num_q    <= '0;
      bram_q   <= '0;
      swr_q    <= '0;
    end else begin
      state    <= state_nx;
      last_q   <= last_nx;
      grant_q  <= grant_nx;
      do_q     <= do_nx;
      ack_q    <= ack_nx;
      done_q   <= done_nx;
      status_q <= status_nx;
      srd_q    <= srd_nx;
      if (load) begin
        cmd_q  <= bus.ch_cmd[int'(pick)*3 +: 3];
        num_q  <= bus.ch_num[int'(pick)*PW +: PW];
        bram_q <= bus.ch_bram[int'(pick)*BW +: BW];
        swr_q  <= bus.ch_spare_wr[int'(pick)*SW +: SW];
      end
    end
  end

`ifdef FTL_OP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Held at zero while idle, so every op starts counting from zero in its first ISSUE cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
      if (timeout_hit && !(bus.op_page_done && (state == WAIT_DONE || bus.op_page_ack)))
        err_q <= 1'b1;
    end
  end

  assign timeout_hit = (state != IDLE) && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign bus.op_page_do       = do_q;
  assign bus.op_page_cmd      = cmd_q;
  assign bus.op_page_num      = num_q;
  assign bus.op_page_bram     = bram_q;
  assign bus.op_page_spare_wr = swr_q;
  assign bus.ch_ack           = ack_q;
  assign bus.ch_done          = done_q;
  assign bus.ch_status        = status_q;
  assign bus.ch_spare_rd      = srd_q;
  assign grant_idx            = grant_q;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_ftl_op_arb.sv
// Randomized bench for ftl_op_arb: a round-robin reference model plus a scripted physical responder.
// Build with FTL_OP_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYC=50 here).
module tb_ftl_op_arb;
  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int BW  = 16;
  localparam int SW  = 42;
  localparam int TO  = 50;
  localparam int IW  = $clog2(NCH);

  logic          clk_50 = 1'b0;
  logic          reset_n;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic          err_timeout;

  logic [2:0]    cmd_d   [NCH];
  logic [PW-1:0] num_d   [NCH];
  logic [BW-1:0] bram_d  [NCH];
  logic [SW-1:0] spare_d [NCH];

  int            checks   = 0;
  int            failures = 0;
  int            last_m;
  logic          last_status_m;
  logic [SW-1:0] last_spare_m;

  ftl_op_arb_if #(.NCH(NCH), .PW(PW), .BW(BW), .SW(SW)) bus ();

  ftl_op_arb #(.NCH(NCH), .PW(PW), .BW(BW), .SW(SW), .TIMEOUT_CYC(TO)) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .bus         (bus),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk_50 = ~clk_50;

  always_comb begin
    bus.ch_cmd      = '0;
    bus.ch_num      = '0;
    bus.ch_bram     = '0;
    bus.ch_spare_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_cmd[i*3 +: 3]       = cmd_d[i];
      bus.ch_num[i*PW +: PW]     = num_d[i];
      bus.ch_bram[i*BW +: BW]    = bram_d[i];
      bus.ch_spare_wr[i*SW +: SW] = spare_d[i];
    end
  end

  // Winner is the first requester met walking upward from the channel after the last winner.
  function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
    for (int k = 1; k <= NCH; k++)
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic randomize_client(input int c);
    cmd_d[c]   = 3'($urandom_range(0, 7));
    num_d[c]   = PW'($urandom());
    bram_d[c]  = BW'($urandom());
    spare_d[c] = SW'({$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    reset_n              = 1'b0;
    bus.ch_do            = '0;
    bus.op_page_ack      = 1'b0;
    bus.op_page_done     = 1'b0;
    bus.op_page_status   = 1'b0;
    bus.op_page_spare_rd = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
    last_m        = NCH - 1;
    last_status_m = 1'b0;
    last_spare_m  = '0;
  endtask

  // One op from grant to completion; caller has already raised ch_do with the arbiter in IDLE.
  task automatic serve_op(input int exp_ch, input int ack_dly, input int done_dly, input bit same,
                          input bit spur, input bit drop, input logic st, input logic [SW-1:0] sp);
    logic [2:0]     cmd_l;
    logic [PW-1:0]  num_l;
    logic [BW-1:0]  bram_l;
    logic [SW-1:0]  swr_l;
    logic [NCH-1:0] onehot;
    onehot         = '0;
    onehot[exp_ch] = 1'b1;
    cmd_l  = cmd_d[exp_ch];
    num_l  = num_d[exp_ch];
    bram_l = bram_d[exp_ch];
    swr_l  = spare_d[exp_ch];
    step();
    checks++;
    if (bus.op_page_do !== 1'b1 || busy !== 1'b1 || grant_idx !== IW'(exp_ch)) begin
      failures++;
      $display("FAIL grant got do=%b busy=%b grant=%0d expected do=1 busy=1 grant=%0d",
               bus.op_page_do, busy, grant_idx, exp_ch);
    end
    checks++;
    if (bus.op_page_cmd !== cmd_l || bus.op_page_num !== num_l ||
        bus.op_page_bram !== bram_l || bus.op_page_spare_wr !== swr_l) begin
      failures++;
      $display("FAIL latch_fields ch=%0d got %h/%h/%h/%h expected %h/%h/%h/%h", exp_ch,
               bus.op_page_cmd, bus.op_page_num, bus.op_page_bram, bus.op_page_spare_wr,
               cmd_l, num_l, bram_l, swr_l);
    end
    randomize_client(exp_ch);
    for (int i = 0; i < ack_dly; i++) begin
      if (spur && i == 0) begin
        bus.op_page_done     = 1'b1;
        bus.op_page_status   = ~last_status_m;
        bus.op_page_spare_rd = SW'({$urandom(), $urandom()});
      end
      step();
      bus.op_page_done = 1'b0;
      if (spur && i == 0) begin
        checks++;
        if (bus.ch_done !== '0 || bus.ch_status !== last_status_m || bus.ch_spare_rd !== last_spare_m) begin
          failures++;
          $display("FAIL done_before_ack got ch_done=%b status=%b expected ch_done=0 status=%b",
                   bus.ch_done, bus.ch_status, last_status_m);
        end
      end
    end
    checks++;
    if (bus.op_page_do !== 1'b1 || bus.op_page_cmd !== cmd_l || bus.op_page_num !== num_l ||
        bus.op_page_bram !== bram_l || bus.op_page_spare_wr !== swr_l) begin
      failures++;
      $display("FAIL hold_until_ack got do=%b cmd=%h num=%h expected do=1 cmd=%h num=%h",
               bus.op_page_do, bus.op_page_cmd, bus.op_page_num, cmd_l, num_l);
    end
    bus.op_page_ack = 1'b1;
    if (same) begin
      bus.op_page_done     = 1'b1;
      bus.op_page_status   = st;
      bus.op_page_spare_rd = sp;
    end
    step();
    bus.op_page_ack  = 1'b0;
    bus.op_page_done = 1'b0;
    if (drop) bus.ch_do[exp_ch] = 1'b0;
    checks++;
    if (bus.ch_ack !== onehot || bus.op_page_do !== 1'b0) begin
      failures++;
      $display("FAIL ack_route got ch_ack=%b do=%b expected ch_ack=%b do=0",
               bus.ch_ack, bus.op_page_do, onehot);
    end
    if (same) begin
      checks++;
      if (bus.ch_done !== onehot || bus.ch_status !== st || bus.ch_spare_rd !== sp || busy !== 1'b0) begin
        failures++;
        $display("FAIL same_cycle got ch_done=%b status=%b spare=%h busy=%b expected %b/%b/%h/0",
                 bus.ch_done, bus.ch_status, bus.ch_spare_rd, busy, onehot, st, sp);
      end
    end else begin
      for (int i = 0; i < done_dly; i++) step();
      checks++;
      if (bus.ch_done !== '0 || busy !== 1'b1 || bus.ch_status !== last_status_m ||
          bus.ch_spare_rd !== last_spare_m) begin
        failures++;
        $display("FAIL wait_done got ch_done=%b busy=%b status=%b spare=%h expected 0/1/%b/%h",
                 bus.ch_done, busy, bus.ch_status, bus.ch_spare_rd, last_status_m, last_spare_m);
      end
      bus.op_page_done     = 1'b1;
      bus.op_page_status   = st;
      bus.op_page_spare_rd = sp;
      step();
      bus.op_page_done = 1'b0;
      checks++;
      if (bus.ch_done !== onehot || bus.ch_ack !== '0 || bus.ch_status !== st ||
          bus.ch_spare_rd !== sp || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_route got ch_done=%b ch_ack=%b status=%b spare=%h busy=%b expected %b/0/%b/%h/0",
                 bus.ch_done, bus.ch_ack, bus.ch_status, bus.ch_spare_rd, busy, onehot, st, sp);
      end
    end
    last_m        = exp_ch;
    last_status_m = st;
    last_spare_m  = sp;
  endtask

  task automatic test_reset();
    reset_n              = 1'b0;
    bus.ch_do            = '1;
    bus.op_page_ack      = 1'b0;
    bus.op_page_done     = 1'b0;
    bus.op_page_status   = 1'b0;
    bus.op_page_spare_rd = '0;
    step();
    checks++;
    if (bus.op_page_do !== 1'b0 || busy !== 1'b0 || grant_idx !== '0 || bus.ch_ack !== '0 ||
        bus.ch_done !== '0 || bus.ch_status !== 1'b0 || bus.ch_spare_rd !== '0 ||
        bus.op_page_cmd !== '0 || bus.op_page_num !== '0 || bus.op_page_bram !== '0 ||
        bus.op_page_spare_wr !== '0 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got do=%b busy=%b grant=%0d ack=%b done=%b err=%b expected all 0",
               bus.op_page_do, busy, grant_idx, bus.ch_ack, bus.ch_done, err_timeout);
    end
    bus.ch_do = '0;
    do_reset();
    step();
    checks++;
    if (busy !== 1'b0 || bus.op_page_do !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got busy=%b do=%b expected 0/0", busy, bus.op_page_do);
    end
  endtask

  task automatic test_single();
    do_reset();
    cmd_d[0]   = 3'd2;
    num_d[0]   = 16'h0123;
    bram_d[0]  = 16'h0040;
    spare_d[0] = 42'h1;
    bus.ch_do  = 4'b0001;
    serve_op(0, 3, 10, 1'b0, 1'b0, 1'b1, 1'b0, 42'h5A);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NCH; c++) randomize_client(c);
    bus.ch_do = '1;
    for (int n = 0; n < 5; n++) begin
      serve_op(n % NCH, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 1'b0, 1'b1,
               1'($urandom_range(0, 1)), SW'({$urandom(), $urandom()}));
      bus.ch_do[n % NCH] = 1'b1;
    end
    bus.ch_do = '0;
    step();
  endtask

  task automatic test_priority();
    do_reset();
    bus.ch_do = 4'b0100;
    serve_op(2, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, SW'($urandom()));
    bus.ch_do = 4'b0101;
    serve_op(0, 2, 2, 1'b0, 1'b1, 1'b1, 1'b1, SW'($urandom()));
    serve_op(2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, SW'($urandom()));
    bus.ch_do[2] = 1'b1;
    serve_op(2, 1, 3, 1'b0, 1'b0, 1'b1, 1'b1, SW'($urandom()));
  endtask

  task automatic test_same_cycle();
    bus.ch_do = 4'b1000;
    serve_op(rr_pick(bus.ch_do, last_m), 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, SW'({$urandom(), $urandom()}));
    step();
    checks++;
    if (busy !== 1'b0 || bus.ch_ack !== '0 || bus.ch_done !== '0) begin
      failures++;
      $display("FAIL same_cycle_idle got busy=%b ack=%b done=%b expected 0/0/0",
               busy, bus.ch_ack, bus.ch_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    randomize_client(2);
    bus.ch_do = 4'b0100;
    step();
    step();
    bus.op_page_ack = 1'b1;
    step();
    bus.op_page_ack = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.op_page_do !== 1'b0 || busy !== 1'b0 || grant_idx !== '0 || bus.ch_ack !== '0 ||
        bus.ch_done !== '0 || bus.op_page_cmd !== '0 || bus.op_page_num !== '0 ||
        bus.op_page_bram !== '0 || bus.op_page_spare_wr !== '0) begin
      failures++;
      $display("FAIL reset_mid got do=%b busy=%b grant=%0d ack=%b done=%b expected all 0",
               bus.op_page_do, busy, grant_idx, bus.ch_ack, bus.ch_done);
    end
    bus.ch_do = '0;
    step();
    reset_n       = 1'b1;
    last_m        = NCH - 1;
    last_status_m = 1'b0;
    last_spare_m  = '0;
    bus.op_page_done     = 1'b1;
    bus.op_page_status   = 1'b1;
    bus.op_page_spare_rd = SW'(7);
    step();
    bus.op_page_done = 1'b0;
    step();
    checks++;
    if (bus.ch_done !== '0 || busy !== 1'b0 || bus.ch_status !== 1'b0) begin
      failures++;
      $display("FAIL done_in_idle got ch_done=%b busy=%b status=%b expected 0/0/0",
               bus.ch_done, busy, bus.ch_status);
    end
    bus.ch_do = '1;
    serve_op(0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, SW'($urandom()));
    bus.ch_do = '0;
    step();
  endtask

  task automatic test_random();
    int exp;
    do_reset();
    for (int c = 0; c < NCH; c++) randomize_client(c);
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < NCH; c++)
        if (!bus.ch_do[c] && $urandom_range(0, 2) == 0) bus.ch_do[c] = 1'b1;
      if (bus.ch_do == '0) bus.ch_do[$urandom_range(0, NCH - 1)] = 1'b1;
      exp = rr_pick(bus.ch_do, last_m);
      serve_op(exp, $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, 1'b1, 1'($urandom_range(0, 1)),
               SW'({$urandom(), $urandom()}));
    end
    bus.ch_do = '0;
    step();
  endtask

`ifdef FTL_OP_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    bus.ch_do = 4'b0010;
    step();
    n = 0;
    while (bus.ch_done === '0 && n < 4 * TO) begin
      step();
      n++;
    end
    bus.ch_do = '0;
    checks++;
    if (n !== TO || bus.ch_done !== 4'b0010 || bus.ch_ack !== 4'b0010 || bus.ch_status !== 1'b1 ||
        bus.ch_spare_rd !== '0 || err_timeout !== 1'b1 || bus.op_page_do !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout got cycles=%0d done=%b ack=%b status=%b err=%b expected %0d/0010/0010/1/1",
               n, bus.ch_done, bus.ch_ack, bus.ch_status, err_timeout, TO);
    end
    last_m        = 1;
    last_status_m = 1'b1;
    last_spare_m  = '0;
    bus.ch_do = 4'b1000;
    serve_op(3, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, SW'($urandom()));
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got err=%b expected 1", err_timeout);
    end
    do_reset();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL err_reset got err=%b expected 0", err_timeout);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    for (int c = 0; c < NCH; c++) randomize_client(c);
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_same_cycle();
    test_reset_mid();
    test_random();
`ifdef FTL_OP_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
